// File: rtl/sprite_object_anim.sv
// Object bounding-box / bitmap-offset generator with 2x scaling, X mirroring,
// right-edge clipping, frame-based animation index and timed blink.
module sprite_object_anim #(
    parameter int OBJECT_WIDTH_X = 64,
    parameter int OBJECT_HEIGHT_Y = 32,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 8,
    parameter int BLINK_FRAMES = 120,
    parameter int BLINK_PERIOD = 8,
    parameter int CLIP_X_MAX = 480,
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic signed [10:0] pixelX,
    input  logic signed [10:0] pixelY,
    input  logic signed [10:0] topLeftX,
    input  logic signed [10:0] topLeftY,
    input  logic               startOfFrame,
    input  logic               animEnable,
    input  logic               blinkReq,
    input  logic               flipX,
    input  logic               scale2x,
    output logic [10:0]        offsetX,
    output logic [10:0]        offsetY,
    output logic [FW-1:0]      frameIndex,
    output logic               drawingRequest,
    output logic               blinkActive
);

    localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int BW = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;

    typedef enum logic {ST_STOPPED, ST_RUNNING} anim_state_t;

    anim_state_t r_state;
    anim_state_t w_state_nxt;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_nxt;
    logic [FW-1:0] w_frame_nxt;
    logic [BW-1:0] r_blink_cnt;
    logic [BW-1:0] w_blink_nxt;

    int   w_dx;
    int   w_dy;
    int   w_wid;
    int   w_hgt;
    int   w_rx;
    int   w_ry;
    int   w_offx;
    int   w_elapsed;
    logic w_inside;
    logic w_visible;
    logic w_draw;

    // Geometry in 32-bit signed arithmetic so negative/off-screen positions never wrap.
    always_comb begin
        w_dx      = int'(pixelX) - int'(topLeftX);
        w_dy      = int'(pixelY) - int'(topLeftY);
        w_wid     = scale2x ? OBJECT_WIDTH_X * 2 : OBJECT_WIDTH_X;
        w_hgt     = scale2x ? OBJECT_HEIGHT_Y * 2 : OBJECT_HEIGHT_Y;
        w_rx      = scale2x ? (w_dx >>> 1) : w_dx;
        w_ry      = scale2x ? (w_dy >>> 1) : w_dy;
        w_offx    = flipX ? (OBJECT_WIDTH_X - 1 - w_rx) : w_rx;
        w_inside  = (w_dx >= 0) && (w_dx < w_wid) && (w_dy >= 0) && (w_dy < w_hgt);
        w_elapsed = BLINK_FRAMES - int'(r_blink_cnt);
        w_visible = !blinkActive || (((w_elapsed / BLINK_PERIOD) % 2) == 0);
        w_draw    = w_inside && (int'(pixelX) <= CLIP_X_MAX) && w_visible;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drawingRequest <= 1'b0;
            offsetX        <= '0;
            offsetY        <= '0;
        end else begin
            drawingRequest <= w_draw;
            offsetX        <= w_draw ? w_offx[10:0] : 11'd0;
            offsetY        <= w_draw ? w_ry[10:0] : 11'd0;
        end
    end

    // Animation: the state change and the frame count both look at the current state.
    always_comb begin
        w_state_nxt = animEnable ? ST_RUNNING : ST_STOPPED;
        w_hold_nxt  = r_hold_cnt;
        w_frame_nxt = frameIndex;
        if (r_state == ST_RUNNING && startOfFrame) begin
            if (int'(r_hold_cnt) == FRAME_HOLD - 1) begin
                w_hold_nxt  = '0;
                w_frame_nxt = (int'(frameIndex) == NUM_FRAMES - 1) ? '0 : frameIndex + FW'(1);
            end else begin
                w_hold_nxt = r_hold_cnt + HW'(1);
            end
        end
        if (w_state_nxt == ST_STOPPED) begin
            w_hold_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= ST_STOPPED;
            r_hold_cnt <= '0;
            frameIndex <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            frameIndex <= w_frame_nxt;
        end
    end

    // A request always wins over a coincident frame tick.
    always_comb begin
        w_blink_nxt = r_blink_cnt;
        if (blinkReq) begin
            w_blink_nxt = BW'(BLINK_FRAMES);
        end else if (startOfFrame && r_blink_cnt != '0) begin
            w_blink_nxt = r_blink_cnt - BW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_blink_cnt <= '0;
            blinkActive <= 1'b0;
        end else begin
            r_blink_cnt <= w_blink_nxt;
            blinkActive <= (w_blink_nxt != '0);
        end
    end

endmodule

// File: tb/tb_sprite_object_anim.sv
// Directed bench for sprite_object_anim: geometry, flip/scale, clip, animation,
// blink phases, coincident blink/frame pulse and asynchronous reset.
module tb_sprite_object_anim;

    logic               clk;
    logic               resetN;
    logic signed [10:0] pixelX, pixelY, topLeftX, topLeftY;
    logic               startOfFrame, animEnable, blinkReq, flipX, scale2x;
    logic [10:0]        offsetX, offsetY;
    logic [1:0]         frameIndex;
    logic               drawingRequest, blinkActive;

    int n_tests = 0;
    int n_fail  = 0;

    sprite_object_anim dut (
        .clk(clk), .resetN(resetN),
        .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
        .startOfFrame(startOfFrame), .animEnable(animEnable), .blinkReq(blinkReq),
        .flipX(flipX), .scale2x(scale2x),
        .offsetX(offsetX), .offsetY(offsetY), .frameIndex(frameIndex),
        .drawingRequest(drawingRequest), .blinkActive(blinkActive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic set_box(input int tx, input int ty, input int px, input int py);
        topLeftX = 11'(tx);
        topLeftY = 11'(ty);
        pixelX   = 11'(px);
        pixelY   = 11'(py);
    endtask

    task automatic check_pix(input string tag, input logic dr, input int ox, input int oy);
        tick();
        check({tag, "_dr"}, 32'(drawingRequest), 32'(dr));
        check({tag, "_ox"}, 32'(offsetX), 32'(ox));
        check({tag, "_oy"}, 32'(offsetY), 32'(oy));
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0; animEnable = 1'b0; blinkReq = 1'b0;
        flipX = 1'b0; scale2x = 1'b0;
        set_box(100, 50, 100, 50);
        tick();
        tick();
        check("rst_dr", 32'(drawingRequest), 0);
        check("rst_ox", 32'(offsetX), 0);
        check("rst_oy", 32'(offsetY), 0);
        check("rst_frame", 32'(frameIndex), 0);
        check("rst_blink", 32'(blinkActive), 0);
        resetN = 1'b1;

        // Plain box hits and misses
        set_box(100, 50, 100, 50);  check_pix("box_tl", 1'b1, 0, 0);
        set_box(100, 50, 163, 81);  check_pix("box_br", 1'b1, 63, 31);
        set_box(100, 50, 164, 50);  check_pix("box_rx", 1'b0, 0, 0);
        set_box(100, 50, 100, 82);  check_pix("box_by", 1'b0, 0, 0);
        set_box(100, 50, 99, 60);   check_pix("box_lx", 1'b0, 0, 0);

        // Flip and 2x scale
        scale2x = 1'b1; flipX = 1'b1;
        set_box(0, 0, 5, 9);        check_pix("fs_a", 1'b1, 61, 4);
        set_box(0, 0, 127, 63);     check_pix("fs_br", 1'b1, 0, 31);
        set_box(0, 0, 128, 0);      check_pix("fs_out", 1'b0, 0, 0);
        scale2x = 1'b0;
        set_box(0, 0, 5, 9);        check_pix("flip_only", 1'b1, 58, 9);
        flipX = 1'b0;

        // Clip column and negative positions
        set_box(450, 10, 481, 20);  check_pix("clip_out", 1'b0, 0, 0);
        set_box(450, 10, 480, 20);  check_pix("clip_edge", 1'b1, 30, 10);
        set_box(-20, -5, 0, 0);     check_pix("neg_in", 1'b1, 20, 5);
        set_box(-20, -5, 44, 0);    check_pix("neg_out", 1'b0, 0, 0);

        // Animation
        animEnable = 1'b1;
        tick();
        pulses(7);  check("anim_7", 32'(frameIndex), 0);
        pulses(1);  check("anim_8", 32'(frameIndex), 1);
        pulses(24); check("anim_wrap", 32'(frameIndex), 0);
        pulses(8);  check("anim_40", 32'(frameIndex), 1);
        pulses(3);
        animEnable = 1'b0;
        tick();
        pulses(8);  check("anim_held", 32'(frameIndex), 1);
        animEnable = 1'b1;
        tick();
        pulses(7);  check("anim_reen7", 32'(frameIndex), 1);
        pulses(1);  check("anim_reen8", 32'(frameIndex), 2);
        animEnable = 1'b0;
        tick();

        // Blink episode
        set_box(100, 50, 110, 60);
        blinkReq = 1'b1;
        tick();
        blinkReq = 1'b0;
        check("blink_on", 32'(blinkActive), 1);
        check_pix("blink_e0", 1'b1, 10, 10);
        pulses(7);  check_pix("blink_e7", 1'b1, 10, 10);
        pulses(1);  check_pix("blink_e8", 1'b0, 0, 0);
        pulses(8);  check_pix("blink_e16", 1'b1, 10, 10);
        pulses(103);
        check("blink_e119", 32'(blinkActive), 1);
        pulses(1);
        check("blink_end", 32'(blinkActive), 0);
        check_pix("blink_after", 1'b1, 10, 10);

        // Request coincident with a frame tick loads the full count
        blinkReq = 1'b1; startOfFrame = 1'b1;
        tick();
        blinkReq = 1'b0; startOfFrame = 1'b0;
        check("coinc_on", 32'(blinkActive), 1);
        pulses(7);  check_pix("coinc_e7", 1'b1, 10, 10);
        pulses(1);  check_pix("coinc_e8", 1'b0, 0, 0);
        pulses(8);  check_pix("coinc_e16", 1'b1, 10, 10);
        check("pre_rst_frame", 32'(frameIndex), 2);

        // Asynchronous reset mid-blink
        #2;
        resetN = 1'b0;
        #1;
        check("arst_dr", 32'(drawingRequest), 0);
        check("arst_ox", 32'(offsetX), 0);
        check("arst_frame", 32'(frameIndex), 0);
        check("arst_blink", 32'(blinkActive), 0);
        tick();
        resetN = 1'b1;
        pulses(8);
        check("post_rst_stopped", 32'(frameIndex), 0);
        check_pix("post_rst_draw", 1'b1, 10, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sprite_object_anim.md
Name: sprite_object_anim

Overview:
- Parametrised successor to the per-object bounding-box/offset generator in the game-controller video path.
- Decides whether the current VGA pixel lies inside an object's on-screen box (optionally 2x scaled), and produces bitmap offsets (optionally X-mirrored) plus an animation frame index.
- Supports a right-edge clip column and a timed blink mode (e.g. post-collision invulnerability).
- Feeds the object's bitmap ROM and the drawing-priority mux.

Parameters:
- OBJECT_WIDTH_X, 64, bitmap width in pixels (unscaled)
- OBJECT_HEIGHT_Y, 32, bitmap height in pixels (unscaled)
- NUM_FRAMES, 4, number of animation frames, >=1
- FRAME_HOLD, 8, video frames each animation frame is held, >=1
- BLINK_FRAMES, 120, video frames a blink episode lasts
- BLINK_PERIOD, 8, video frames per visible/hidden half-phase
- CLIP_X_MAX, 480, pixels with pixelX > CLIP_X_MAX are never drawn

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- pixelX  in  11 signed  current pixel column
- pixelY  in  11 signed  current pixel row
- topLeftX  in  11 signed  object top-left column
- topLeftY  in  11 signed  object top-left row
- startOfFrame  in  1  one-clk pulse per video frame
- animEnable  in  1  level; 1 = animation runs
- blinkReq  in  1  one-clk pulse; starts or restarts a blink episode
- flipX  in  1  level; 1 = horizontally mirrored bitmap
- scale2x  in  1  level; 1 = each bitmap pixel drawn as 2x2
- offsetX  out  11  bitmap column
- offsetY  out  11  bitmap row
- frameIndex  out  $clog2(NUM_FRAMES) (min 1)  current animation frame
- drawingRequest  out  1  pixel belongs to object
- blinkActive  out  1  blink episode in progress

Behaviour:
- Reset (async, resetN=0):
  - Outputs: offsetX=0, offsetY=0, frameIndex=0, drawingRequest=0, blinkActive=0.
  - Internal: holdCnt=0, blinkCnt=0, animation FSM=STOPPED.
- Geometry (combinational, all signed int arithmetic):
  - s = scale2x.
  - W = OBJECT_WIDTH_X<<s, H = OBJECT_HEIGHT_Y<<s.
  - inside = pixelX>=topLeftX && pixelX<topLeftX+W && pixelY>=topLeftY && pixelY<topLeftY+H.
  - Negative or off-screen topLeft values must work; no unsigned wrap.
- Offsets:
  - rx = (pixelX-topLeftX)>>s, ry = (pixelY-topLeftY)>>s.
  - offsetX = flipX ? OBJECT_WIDTH_X-1-rx : rx; offsetY = ry.
- Pixel output, registered, 1-clk latency from pixel inputs:
  - Default each clk: drawingRequest=0, offsets=0.
  - If inside && pixelX<=CLIP_X_MAX && visible: drawingRequest=1 and offsets as above.
  - If inside but clipped or hidden: drawingRequest=0, offsets=0.
- Animation FSM, states STOPPED and RUNNING:
  - STOPPED -> RUNNING when animEnable=1; RUNNING -> STOPPED when animEnable=0.
  - On entering STOPPED: holdCnt cleared; frameIndex is held, not reset.
  - In RUNNING, on each startOfFrame: if holdCnt==FRAME_HOLD-1, then holdCnt=0 and frameIndex advances, wrapping NUM_FRAMES-1 -> 0; otherwise holdCnt++.
  - NUM_FRAMES=1: frameIndex stays 0.
  - The FSM state update and the startOfFrame count are both evaluated from the current state in the same clk.
- Blink:
  - blinkReq loads blinkCnt=BLINK_FRAMES and sets blinkActive=1 on the next clk.
  - Each startOfFrame while blinkCnt>0 decrements blinkCnt.
  - blinkActive = (blinkCnt!=0), registered.
  - elapsed = BLINK_FRAMES-blinkCnt; visible = !blinkActive || ((elapsed/BLINK_PERIOD) even). The first BLINK_PERIOD frames are therefore hidden... no: elapsed=0 gives even, so the first half-phase is visible.
  - blinkReq and startOfFrame in the same clk: the load wins, no decrement.
  - blinkReq during an active blink restarts from BLINK_FRAMES.
  - Blink is independent of the animation FSM; animation continues while blinking.
- Level inputs (flipX, scale2x) may change at any time and take effect on the next registered pixel.
- A reset asserted mid-frame or mid-blink immediately forces all reset values.

Test Plan:
- Box hit: topLeft=(100,50), scale2x=0, flipX=0, pixel (100,50) -> next clk drawingRequest=1, offsets (0,0); pixel (163,81) -> (63,31); pixel (164,50) -> drawingRequest=0.
- Flip and scale: scale2x=1, flipX=1, topLeft=(0,0), pixel (5,9) -> offsetX=61, offsetY=4; pixel (127,63) -> drawingRequest=1; pixel (128,0) -> 0.
- Clip and negative position: topLeft=(450,10), pixel (481,20) -> drawingRequest=0, offsets 0. topLeft=(-20,-5), pixel (0,0) -> drawingRequest=1, offsets (20,5).
- Animation: animEnable=1, 8 startOfFrame pulses -> frameIndex 0->1. After 32 pulses -> wraps to 0. Drop animEnable after 3 pulses -> frameIndex held. Re-enable -> needs a full 8 further pulses to advance.
- Blink: blinkReq -> blinkActive=1 next clk. Pixel inside the box is drawn for frames 0-7, suppressed for frames 8-15, and so on. blinkActive=0 after 120 pulses. blinkReq coincident with startOfFrame -> blinkCnt=120, not 119.
- Reset: assert resetN=0 mid-blink with frameIndex=2 -> all outputs 0 asynchronously, FSM STOPPED.
